// File: rtl/tb_mem_arbiter.sv
// Two-client arbiter/sequencer for the single-ported tb_memory.
// Round-robin on contention, registered memory command, one idle edge of
// req_rdwr between accesses, and a watchdog that aborts a stuck access.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a request; grants and registers the command
// ACCESS   | command held on mem_*, waiting for data_ready or timeout
// RECOVER  | req_rdwr low for one edge so the memory re-arms
module tb_mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_sz,
  input  logic              c0_we,
  input  logic [7:0]        c0_wdata_8,
  input  logic [15:0]       c0_wdata_16,
  output logic              c0_done,
  output logic              c0_err,
  output logic [7:0]        c0_rdata_8,
  output logic [15:0]       c0_rdata_16,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_sz,
  input  logic              c1_we,
  input  logic [7:0]        c1_wdata_8,
  input  logic [15:0]       c1_wdata_16,
  output logic              c1_done,
  output logic              c1_err,
  output logic [7:0]        c1_rdata_8,
  output logic [15:0]       c1_rdata_16,
  output logic              mem_req_rdwr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data_acc_sz,
  output logic              mem_we_8,
  output logic              mem_we_16,
  output logic [7:0]        mem_wdata_8,
  output logic [15:0]       mem_wdata_16,
  input  logic [7:0]        mem_rdata_8,
  input  logic [15:0]       mem_rdata_16,
  input  logic              mem_data_ready,
  output logic              busy,
  output logic              grant_id
);

  // Access-size encoding shared with the CPU side (8-bit = 0, 16-bit = 1).
  localparam logic SZ_8  = 1'b0;
  localparam logic SZ_16 = 1'b1;
  // Watchdog value on which the next ACCESS edge would reach the limit.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RECOVER} state_t;

  state_t     state_q, state_nx;
  logic       prio_q;
  logic [7:0] wd_q;
  logic       grant_vld, winner, acc_ok, acc_to;

  logic              sel_sz, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata_8;
  logic [15:0]       sel_wdata_16;
  logic              acc_is_read;

  // Command of the client that would win this cycle.
  always_comb begin
    sel_addr     = winner ? c1_addr     : c0_addr;
    sel_sz       = winner ? c1_sz       : c0_sz;
    sel_we       = winner ? c1_we       : c0_we;
    sel_wdata_8  = winner ? c1_wdata_8  : c0_wdata_8;
    sel_wdata_16 = winner ? c1_wdata_16 : c0_wdata_16;
  end

  assign acc_is_read = ~(mem_we_8 | mem_we_16);
  assign busy        = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next state, arbitration and completion decisions; ready beats timeout.
  always_comb begin
    state_nx  = state_q;
    grant_vld = 1'b0;
    winner    = 1'b0;
    acc_ok    = 1'b0;
    acc_to    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c0_req || c1_req) begin
          grant_vld = 1'b1;
          winner    = (c0_req && c1_req) ? prio_q : c1_req;
          state_nx  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_data_ready) begin
          acc_ok   = 1'b1;
          state_nx = ST_RECOVER;
        end else if (wd_q == WD_LAST) begin
          acc_to   = 1'b1;
          state_nx = ST_RECOVER;
        end
      end
      ST_RECOVER: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Memory command, watchdog, priority pointer and client responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q          <= 1'b0;
      wd_q            <= '0;
      mem_req_rdwr    <= 1'b0;
      mem_addr        <= '0;
      mem_data_acc_sz <= 1'b0;
      mem_we_8        <= 1'b0;
      mem_we_16       <= 1'b0;
      mem_wdata_8     <= '0;
      mem_wdata_16    <= '0;
      grant_id        <= 1'b0;
      c0_done         <= 1'b0;
      c0_err          <= 1'b0;
      c0_rdata_8      <= '0;
      c0_rdata_16     <= '0;
      c1_done         <= 1'b0;
      c1_err          <= 1'b0;
      c1_rdata_8      <= '0;
      c1_rdata_16     <= '0;
    end else begin
      c0_done <= 1'b0;
      c0_err  <= 1'b0;
      c1_done <= 1'b0;
      c1_err  <= 1'b0;
      if (grant_vld) begin
        mem_req_rdwr    <= 1'b1;
        mem_addr        <= sel_addr;
        mem_data_acc_sz <= sel_sz;
        mem_we_8        <= sel_we & (sel_sz == SZ_8);
        mem_we_16       <= sel_we & (sel_sz == SZ_16);
        mem_wdata_8     <= sel_wdata_8;
        mem_wdata_16    <= sel_wdata_16;
        grant_id        <= winner;
        wd_q            <= '0;
        if (c0_req && c1_req) prio_q <= ~winner;
      end
      if (state_q == ST_ACCESS) begin
        if (acc_ok || acc_to) begin
          mem_req_rdwr <= 1'b0;
          mem_we_8     <= 1'b0;
          mem_we_16    <= 1'b0;
          if (grant_id) begin
            c1_done <= 1'b1;
            c1_err  <= acc_to;
          end else begin
            c0_done <= 1'b1;
            c0_err  <= acc_to;
          end
          if (acc_ok && acc_is_read) begin
            if (grant_id) begin
              c1_rdata_8  <= mem_rdata_8;
              c1_rdata_16 <= mem_rdata_16;
            end else begin
              c0_rdata_8  <= mem_rdata_8;
              c0_rdata_16 <= mem_rdata_16;
            end
          end
        end else begin
          wd_q <= wd_q + 8'd1;
        end
      end
      if (state_q == ST_RECOVER) wd_q <= '0;
    end
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Scoreboard bench for tb_mem_arbiter: directed scenarios plus randomized
// traffic from both clients, checked against a byte-array memory model.
module tb_tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int TO     = 8;
  localparam logic SZ8  = 1'b0;
  localparam logic SZ16 = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              c0_req = 0, c0_sz = 0, c0_we = 0;
  logic [ADDR_W-1:0] c0_addr = '0;
  logic [7:0]        c0_wdata_8 = '0;
  logic [15:0]       c0_wdata_16 = '0;
  logic              c0_done, c0_err;
  logic [7:0]        c0_rdata_8;
  logic [15:0]       c0_rdata_16;
  logic              c1_req = 0, c1_sz = 0, c1_we = 0;
  logic [ADDR_W-1:0] c1_addr = '0;
  logic [7:0]        c1_wdata_8 = '0;
  logic [15:0]       c1_wdata_16 = '0;
  logic              c1_done, c1_err;
  logic [7:0]        c1_rdata_8;
  logic [15:0]       c1_rdata_16;
  logic              mem_req_rdwr, mem_data_acc_sz, mem_we_8, mem_we_16;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata_8;
  logic [15:0]       mem_wdata_16;
  logic [7:0]        mem_rdata_8 = '0;
  logic [15:0]       mem_rdata_16 = '0;
  logic              mem_data_ready = 1'b0;
  logic              busy, grant_id;

  always #5 clk = ~clk;

  tb_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst_n),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_sz(c0_sz), .c0_we(c0_we),
    .c0_wdata_8(c0_wdata_8), .c0_wdata_16(c0_wdata_16),
    .c0_done(c0_done), .c0_err(c0_err), .c0_rdata_8(c0_rdata_8), .c0_rdata_16(c0_rdata_16),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_sz(c1_sz), .c1_we(c1_we),
    .c1_wdata_8(c1_wdata_8), .c1_wdata_16(c1_wdata_16),
    .c1_done(c1_done), .c1_err(c1_err), .c1_rdata_8(c1_rdata_8), .c1_rdata_16(c1_rdata_16),
    .mem_req_rdwr(mem_req_rdwr), .mem_addr(mem_addr), .mem_data_acc_sz(mem_data_acc_sz),
    .mem_we_8(mem_we_8), .mem_we_16(mem_we_16),
    .mem_wdata_8(mem_wdata_8), .mem_wdata_16(mem_wdata_16),
    .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16),
    .mem_data_ready(mem_data_ready), .busy(busy), .grant_id(grant_id)
  );

  // ---------------- memory stub (behaves like tb_memory) ----------------
  logic [7:0] stub_mem [0:4095];
  logic       stub_tog = 1'b0;
  logic       stall = 1'b0;
  int         n_wr = 0, n_acc = 0;

  // One access per req_rdwr high period; re-arms when req_rdwr is seen low.
  always @(posedge clk) begin
    if (mem_req_rdwr && !stub_tog && !stall) begin
      stub_tog       <= 1'b1;
      mem_data_ready <= 1'b1;
      mem_rdata_8    <= stub_mem[mem_addr[11:0]];
      mem_rdata_16   <= {stub_mem[mem_addr[11:0] + 12'd1], stub_mem[mem_addr[11:0]]};
      n_acc = n_acc + 1;
      if (mem_we_8) begin
        stub_mem[mem_addr[11:0]] <= mem_wdata_8;
        n_wr = n_wr + 1;
      end
      if (mem_we_16) begin
        stub_mem[mem_addr[11:0]]         <= mem_wdata_16[7:0];
        stub_mem[mem_addr[11:0] + 12'd1] <= mem_wdata_16[15:8];
        n_wr = n_wr + 1;
      end
    end else if (!mem_req_rdwr) begin
      stub_tog       <= 1'b0;
      mem_data_ready <= 1'b0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        err;
    logic [7:0]  r8;
    logic [15:0] r16;
    int          lat;
  } exp_t;
  typedef struct {
    logic id;
    int   cyc;
  } grant_t;

  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  m_r8  [2];
  logic [15:0] m_r16 [2];
  exp_t        exp_q0[$], exp_q1[$];
  grant_t      glog[$];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  int          gcyc [2];
  logic        prev_req = 1'b0;
  logic [1:0]  prev_done = 2'b00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_r8[c]  = '0;
      m_r16[c] = '0;
    end
  endfunction

  // Apply one transaction to the model and queue the response the client must see.
  function automatic void exp_push(int c, logic we, logic sz, logic [15:0] a,
                                   logic [15:0] wd, logic stalled);
    exp_t        it;
    logic [11:0] ix;
    ix = a[11:0];
    if (!stalled) begin
      if (we) begin
        if (sz == SZ8) ref_mem[ix] = wd[7:0];
        else begin
          ref_mem[ix]         = wd[7:0];
          ref_mem[ix + 12'd1] = wd[15:8];
        end
      end else begin
        m_r8[c]  = ref_mem[ix];
        m_r16[c] = {ref_mem[ix + 12'd1], ref_mem[ix]};
      end
    end
    it.err = stalled;
    it.r8  = m_r8[c];
    it.r16 = m_r16[c];
    it.lat = stalled ? TO : 2;
    if (c == 0) exp_q0.push_back(it);
    else        exp_q1.push_back(it);
  endfunction

  task automatic drive_cmd(int c, logic we, logic sz, logic [15:0] a, logic [15:0] wd);
    if (c == 0) begin
      c0_we = we; c0_sz = sz; c0_addr = a; c0_wdata_8 = wd[7:0]; c0_wdata_16 = wd;
    end else begin
      c1_we = we; c1_sz = sz; c1_addr = a; c1_wdata_8 = wd[7:0]; c1_wdata_16 = wd;
    end
  endtask

  // Issue one request, hold it until done (bounded), then release it.
  task automatic do_xfer(int c, logic we, logic sz, logic [15:0] a, logic [15:0] wd,
                         logic stalled, int gap);
    logic seen;
    exp_push(c, we, sz, a, wd, stalled);
    drive_cmd(c, we, sz, a, wd);
    if (c == 0) c0_req = 1'b1; else c1_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (c == 0) ? c0_done : c1_done;
    end
    if (c == 0) c0_req = 1'b0; else c1_req = 1'b0;
    chk("xfer_done_seen", 32'(seen), 32'd1);
    chk("req_dropped_at_done", 32'(mem_req_rdwr), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: log grants, pop expected responses on every done pulse.
  always @(negedge clk) begin
    exp_t it;
    logic dn, er;
    logic [7:0] r8;
    logic [15:0] r16;
    cyc++;
    if (mem_req_rdwr && !prev_req) begin
      gcyc[grant_id] = cyc;
      glog.push_back('{grant_id, cyc});
    end
    prev_req = mem_req_rdwr;
    if (c0_done || c1_done) chk("done_exclusive", 32'(c0_done & c1_done), 32'd0);
    for (int c = 0; c < 2; c++) begin
      dn  = (c == 0) ? c0_done     : c1_done;
      er  = (c == 0) ? c0_err      : c1_err;
      r8  = (c == 0) ? c0_rdata_8  : c1_rdata_8;
      r16 = (c == 0) ? c0_rdata_16 : c1_rdata_16;
      if (dn) begin
        chk("done_one_cycle", 32'(prev_done[c]), 32'd0);
        if ((c == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: client %0d done with empty queue", c);
        end else begin
          it = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("err", 32'(er), 32'(it.err));
          chk("rdata_8", 32'(r8), 32'(it.r8));
          chk("rdata_16", 32'(r16), 32'(it.r16));
          chk("grant_to_done", 32'(cyc - gcyc[c]), 32'(it.lat));
        end
      end
    end
    prev_done = {c1_done, c0_done};
  end

  // ---------------- stimulus ----------------
  initial begin
    int w0, a0, cnt;
    logic [15:0] hw;
    for (int i = 0; i < 4096; i++) begin
      stub_mem[i] = 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end
    stub_mem[12'h010] = 8'hEF; ref_mem[12'h010] = 8'hEF;
    stub_mem[12'h011] = 8'hBE; ref_mem[12'h011] = 8'hBE;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_rdwr", 32'(mem_req_rdwr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({c1_done, c0_done}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 32'(mem_req_rdwr), 32'd0);

    // Single 16-bit read of 0xBEEF
    do_xfer(0, 1'b0, SZ16, 16'h0010, 16'h0000, 1'b0, 2);

    // Write then read back through the other client
    w0 = n_wr;
    do_xfer(1, 1'b1, SZ8, 16'h0200, 16'h00A5, 1'b0, 1);
    do_xfer(0, 1'b0, SZ8, 16'h0200, 16'h0000, 1'b0, 1);
    chk("single_write_logged", 32'(n_wr - w0), 32'd1);

    // Timeout on a stalled memory, then normal service
    stall = 1'b1;
    do_xfer(1, 1'b0, SZ16, 16'h0300, 16'h0000, 1'b1, 0);
    stall = 1'b0;
    do_xfer(0, 1'b0, SZ16, 16'h0010, 16'h0000, 1'b0, 2);

    // Contention from reset release
    rst_n = 1'b0;
    model_reset();
    drive_cmd(0, 1'b0, SZ16, 16'h0010, 16'h0000);
    drive_cmd(1, 1'b0, SZ8, 16'h0200, 16'h0000);
    exp_push(0, 1'b0, SZ16, 16'h0010, 16'h0000, 1'b0);
    exp_push(1, 1'b0, SZ8, 16'h0200, 16'h0000, 1'b0);
    exp_push(0, 1'b0, SZ16, 16'h0010, 16'h0000, 1'b0);
    exp_push(1, 1'b0, SZ8, 16'h0200, 16'h0000, 1'b0);
    c0_req = 1'b1; c1_req = 1'b1;
    repeat (2) @(negedge clk);
    glog.delete();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 4; i++) begin
      @(negedge clk);
      if (c0_done || c1_done) cnt++;
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk("contention_dones", 32'(cnt), 32'd4);
    chk("contention_grants", 32'(glog.size() >= 4), 32'd1);
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("contention_order", 32'(glog[i].id), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("contention_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd4);
    end
    repeat (4) @(negedge clk);

    // Reset in the middle of an access
    drive_cmd(0, 1'b0, SZ16, 16'h0010, 16'h0000);
    c0_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && !mem_req_rdwr; i++) @(negedge clk);
    chk("mid_access_reached", 32'(mem_req_rdwr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_rdwr", 32'(mem_req_rdwr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rdata", 32'(c0_rdata_16), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    model_reset();
    exp_push(0, 1'b0, SZ16, 16'h0010, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("regrant_first_edge", 32'(mem_req_rdwr), 32'd1);
    chk("regrant_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && !c0_done; i++) @(negedge clk);
    c0_req = 1'b0;
    repeat (3) @(negedge clk);

    // Held request: five back-to-back 16-bit writes
    w0 = n_wr; a0 = n_acc;
    hw = 16'($urandom);
    drive_cmd(0, 1'b1, SZ16, 16'h0040, hw);
    for (int i = 0; i < 5; i++) exp_push(0, 1'b1, SZ16, 16'h0040, hw, 1'b0);
    c0_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      @(negedge clk);
      if (c0_done) cnt++;
    end
    c0_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_dones", 32'(cnt), 32'd5);
    chk("held_writes", 32'(n_wr - w0), 32'd5);
    chk("held_accesses", 32'(n_acc - a0), 32'd5);
    do_xfer(0, 1'b0, SZ16, 16'h0040, 16'h0000, 1'b0, 1);

    // Randomized traffic, clients in disjoint address regions
    fork
      begin
        for (int i = 0; i < 25; i++)
          do_xfer(0, 1'($urandom), 1'($urandom), 16'($urandom_range(0, 254)),
                  16'($urandom), 1'b0, int'($urandom_range(0, 3)));
      end
      begin
        for (int i = 0; i < 25; i++)
          do_xfer(1, 1'($urandom), 1'($urandom), 16'(256 + $urandom_range(0, 254)),
                  16'($urandom), 1'b0, int'($urandom_range(0, 3)));
      end
    join

    repeat (10) @(negedge clk);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
